imm_gen_pipe: RTL and testbench

Parametrised, registered successor to the combinational immediate generator. It sits between fetch and the ID/EX register. It decodes all RV32I/RV64I immediate formats (I, shift, S, B, U, J), not only loads, OP-IMM, stores and branches. It returns the format class and an illegal-opcode flag. Decoded results pass through a 2-entry elastic buffer with valid/ready handshakes and flush, so fetch stalls decouple from decode at full throughput.

---
 rtl/imm_pkg.sv | 32 +++
 rtl/imm_decode.sv | 91 +++++++++
 rtl/imm_gen_pipe.sv | 114 +++++++++++
 tb/tb_imm_gen_pipe.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: RV32I/RV64I major opcodes,
// the funct3 codes that change how an immediate is extended, and the
// immediate format class reported alongside each decoded word.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [2:0] FUNCT3_LBU  = 3'b100;
  localparam logic [2:0] FUNCT3_SLLI = 3'b001;
  localparam logic [2:0] FUNCT3_SRXI = 3'b101;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_SH,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder for all RV32I/RV64I immediate formats.
// Ports:
//   inst    - raw 32-bit instruction word
//   imm     - immediate extended to XLEN bits (0 when the format has none)
//   fmt     - format class of the immediate
//   illegal - opcode is outside the supported set
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit ZEXT_LBU_IMM = 1'b0
) (
  input  logic        [31:0]     inst,
  output logic signed [XLEN-1:0] imm,
  output imm_fmt_e               fmt,
  output logic                   illegal
);

  logic [6:0] opc;
  logic [2:0] funct3;

  assign opc    = inst[6:0];
  assign funct3 = inst[14:12];

  // Every immediate is first assembled as a 32-bit value; these widen it to XLEN.
  function automatic logic signed [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic signed [XLEN-1:0] zext32(input logic [31:0] v);
    return XLEN'(v);
  endfunction

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opc)
      OPC_LOAD: begin
        fmt = FMT_I;
        // Legacy consumers expect the LBU offset unsigned.
        if (ZEXT_LBU_IMM && funct3 == FUNCT3_LBU) begin
          imm = zext32({20'b0, inst[31:20]});
        end else begin
          imm = sext32({{20{inst[31]}}, inst[31:20]});
        end
      end
      OPC_JALR: begin
        fmt = FMT_I;
        imm = sext32({{20{inst[31]}}, inst[31:20]});
      end
      OPC_OPIMM: begin
        if (funct3 == FUNCT3_SLLI || funct3 == FUNCT3_SRXI) begin
          fmt = FMT_SH;
          // RV64 shifts use a 6-bit shamt; bit 25 is part of funct7 on RV32.
          if (XLEN == 64) begin
            imm = zext32({26'b0, inst[25:20]});
          end else begin
            imm = zext32({27'b0, inst[24:20]});
          end
        end else begin
          fmt = FMT_I;
          imm = sext32({{20{inst[31]}}, inst[31:20]});
        end
      end
      OPC_STORE: begin
        fmt = FMT_S;
        imm = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        imm = sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        imm = sext32({inst[31:12], 12'b0});
      end
      OPC_JAL: begin
        fmt = FMT_J;
        imm = sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
      end
      OPC_OP, OPC_SYSTEM, OPC_FENCE: begin
        fmt = FMT_NONE;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decodes the incoming instruction and queues
// {imm, fmt, illegal, tag} in a 2-entry elastic buffer with valid/ready on
// both sides, so fetch stalls are decoupled from decode at full throughput.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   flush                 - drop all buffered entries, ignore this cycle's input
//   in_valid/in_ready     - upstream handshake (in_ready = room in buffer)
//   in_inst/in_tag        - instruction word and pass-through sideband tag
//   out_valid/out_ready   - downstream handshake on the head entry
//   out_imm/out_fmt/out_illegal/out_tag - head entry contents
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int TAG_W        = 8,
  parameter bit ZEXT_LBU_IMM = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output imm_fmt_e         out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_fmt_e         fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic signed [XLEN-1:0] dec_imm_p0;
  imm_fmt_e               dec_fmt_p0;
  logic                   dec_illegal_p0;
  entry_t                 new_p0;

  entry_t     head_p1;
  entry_t     tail_p1;
  logic [1:0] count_p1;
  logic       push;
  logic       pop;

  // ---- p0: combinational decode of the incoming word ----
  imm_decode #(
    .XLEN        (XLEN),
    .ZEXT_LBU_IMM(ZEXT_LBU_IMM)
  ) u_decode (
    .inst   (in_inst),
    .imm    (dec_imm_p0),
    .fmt    (dec_fmt_p0),
    .illegal(dec_illegal_p0)
  );

  assign new_p0 = '{imm: dec_imm_p0, fmt: dec_fmt_p0, illegal: dec_illegal_p0, tag: in_tag};

  assign in_ready  = (count_p1 != 2'd2);
  assign out_valid = (count_p1 != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // ---- p1: elastic buffer; head_p1 drives the outputs directly ----
  // Head is reset so the outputs come up at known values; the tail is
  // only ever read after being written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_p1 <= 2'd0;
      head_p1  <= '0;
    end else if (flush) begin
      count_p1 <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          count_p1 <= count_p1 + 2'd1;
          if (count_p1 == 2'd0) head_p1 <= new_p0;
        end
        2'b01: begin
          count_p1 <= count_p1 - 2'd1;
          if (count_p1 == 2'd2) head_p1 <= tail_p1;
        end
        // Push and pop together only happen at count 1: new word becomes head.
        2'b11:   head_p1 <= new_p0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !pop && count_p1 == 2'd1) tail_p1 <= new_p0;
  end

  assign out_imm     = head_p1.imm;
  assign out_fmt     = head_p1.fmt;
  assign out_illegal = head_p1.illegal;
  assign out_tag     = head_p1.tag;

  a_xlen_legal: assert property (@(posedge clk) (XLEN == 32 || XLEN == 64))
    else $error("imm_gen_pipe: XLEN must be 32 or 64");

  a_count_max: assert property (@(posedge clk) disable iff (reset) count_p1 <= 2'd2)
    else $error("imm_gen_pipe: buffer count exceeds 2");

  a_in_stable: assert property (@(posedge clk) disable iff (reset)
    (in_valid && !in_ready && !flush) |=> ($stable(in_inst) && $stable(in_tag)))
    else $error("imm_gen_pipe: in_inst/in_tag changed while stalled");

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [7:0]  in_tag;

  // a: XLEN=32 ISA mode, b: XLEN=64, c: XLEN=32 legacy LBU zero-extension
  logic        rdy_a, vld_a, ill_a, rdy_b, vld_b, ill_b, rdy_c, vld_c, ill_c;
  logic [31:0] imm_a, imm_c;
  logic [63:0] imm_b;
  imm_fmt_e    fmt_a, fmt_b, fmt_c;
  logic [7:0]  tag_a, tag_b, tag_c;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .ZEXT_LBU_IMM(1'b0)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(vld_a), .out_ready(out_ready),
    .out_imm(imm_a), .out_fmt(fmt_a), .out_illegal(ill_a), .out_tag(tag_a));

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .ZEXT_LBU_IMM(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(vld_b), .out_ready(out_ready),
    .out_imm(imm_b), .out_fmt(fmt_b), .out_illegal(ill_b), .out_tag(tag_b));

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .ZEXT_LBU_IMM(1'b1)) dut_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(vld_c), .out_ready(out_ready),
    .out_imm(imm_c), .out_fmt(fmt_c), .out_illegal(ill_c), .out_tag(tag_c));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] inst;
    logic [7:0]  tag;
  } ent_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] e32;
    logic [63:0] e64;
    logic [31:0] ez;
    imm_fmt_e    fmt;
    logic        ill;
  } vec_t;

  ent_t       q[$];
  logic [7:0] delivered[$];
  bit         last_stall;
  vec_t       tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sx(input longint val, input int bits);
    longint half;
    half = longint'(1) << (bits - 1);
    return (val >= half) ? val - 2 * half : val;
  endfunction

  // Reference decoder: immediates rebuilt by weighting instruction fields.
  function automatic logic [63:0] model(input logic [31:0] i, input int xlen, input bit zext,
                                        output logic [2:0] fmt, output bit ill);
    longint v;
    int     f3;
    v   = 0;
    f3  = int'(i[14:12]);
    fmt = FMT_NONE;
    ill = 1'b0;
    case (i[6:0])
      7'h03, 7'h67: begin
        fmt = FMT_I;
        if (zext && i[6:0] == 7'h03 && f3 == 4) v = longint'(i[31:20]);
        else v = sx(longint'(i[31:20]), 12);
      end
      7'h13: begin
        if (f3 == 1 || f3 == 5) begin
          fmt = FMT_SH;
          v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
        end else begin
          fmt = FMT_I;
          v = sx(longint'(i[31:20]), 12);
        end
      end
      7'h23: begin
        fmt = FMT_S;
        v = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
      end
      7'h63: begin
        fmt = FMT_B;
        v = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
               + longint'(i[11:8]) * 2, 13);
      end
      7'h37, 7'h17: begin
        fmt = FMT_U;
        v = sx(longint'(i[31:12]) * 4096, 32);
      end
      7'h6F: begin
        fmt = FMT_J;
        v = sx(longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
               + longint'(i[30:21]) * 2, 21);
      end
      7'h33, 7'h73, 7'h0F: ;
      default: ill = 1'b1;
    endcase
    if (xlen == 32) return {32'b0, v[31:0]};
    return v;
  endfunction

  task automatic check_head(input ent_t e);
    logic [63:0] v;
    logic [2:0]  f;
    bit          il;
    v = model(e.inst, 32, 1'b0, f, il);
    chk("head_imm32", imm_a, v);
    chk("head_fmt32", fmt_a, f);
    chk("head_ill32", ill_a, il);
    chk("head_tag32", tag_a, e.tag);
    v = model(e.inst, 64, 1'b0, f, il);
    chk("head_imm64", imm_b, v);
    chk("head_fmt64", fmt_b, f);
    chk("head_tag64", tag_b, e.tag);
    v = model(e.inst, 32, 1'b1, f, il);
    chk("head_immz", imm_c, v);
    chk("head_fmtz", fmt_c, f);
  endtask

  // One clock: compare at the falling edge, update the reference queue at
  // the rising edge, return 1 time unit after it.
  task automatic cycle();
    bit push, pop;
    @(negedge clk);
    chk("out_valid", vld_a, q.size() != 0);
    chk("in_ready", rdy_a, q.size() < 2);
    chk("out_valid64", vld_b, q.size() != 0);
    push = in_valid && q.size() < 2 && !flush && !reset;
    pop  = out_ready && q.size() != 0 && !flush && !reset;
    last_stall = in_valid && q.size() >= 2 && !flush && !reset;
    if (pop) begin
      check_head(q[0]);
      delivered.push_back(tag_a);
    end
    @(posedge clk);
    if (reset || flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{inst: in_inst, tag: in_tag});
    end
    #1;
  endtask

  task automatic check_reset_values(input string nm);
    chk({nm, "_valid"}, vld_a, 1'b0);
    chk({nm, "_in_ready"}, rdy_a, 1'b1);
    chk({nm, "_imm"}, imm_a, 0);
    chk({nm, "_imm64"}, imm_b, 0);
    chk({nm, "_fmt"}, fmt_a, FMT_NONE);
    chk({nm, "_illegal"}, ill_a, 1'b0);
    chk({nm, "_tag"}, tag_a, 0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops[12] = '{7'h03, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17,
                             7'h6F, 7'h67, 7'h33, 7'h73, 7'h0F, 7'h13};
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 12);
    if (k < 12) w[6:0] = ops[k];
    return w;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'hFFC4A303, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, FMT_I,    1'b0};
    tbl[1]  = '{32'h0054D293, 32'h00000005, 64'h0000000000000005, 32'h00000005, FMT_SH,   1'b0};
    tbl[2]  = '{32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, FMT_S,    1'b0};
    tbl[3]  = '{32'hFE0008E3, 32'hFFFFFFF0, 64'hFFFFFFFFFFFFFFF0, 32'hFFFFFFF0, FMT_B,    1'b0};
    tbl[4]  = '{32'h123452B7, 32'h12345000, 64'h0000000012345000, 32'h12345000, FMT_U,    1'b0};
    tbl[5]  = '{32'h008000EF, 32'h00000008, 64'h0000000000000008, 32'h00000008, FMT_J,    1'b0};
    tbl[6]  = '{32'h02129293, 32'h00000001, 64'h0000000000000021, 32'h00000001, FMT_SH,   1'b0};
    tbl[7]  = '{32'h80000537, 32'h80000000, 64'hFFFFFFFF80000000, 32'h80000000, FMT_U,    1'b0};
    tbl[8]  = '{32'hFFF54503, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 32'h00000FFF, FMT_I,    1'b0};
    tbl[9]  = '{32'h0000007F, 32'h00000000, 64'h0000000000000000, 32'h00000000, FMT_NONE, 1'b1};
    tbl[10] = '{32'h00B50533, 32'h00000000, 64'h0000000000000000, 32'h00000000, FMT_NONE, 1'b0};
    tbl[11] = '{32'hFFF50567, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, FMT_I,    1'b0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_tag = '0; last_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_values("reset");

    // Streaming table, one word per cycle, result visible one cycle later.
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      in_valid = 1'b1;
      in_inst  = tbl[i].inst;
      in_tag   = 8'(i + 16);
      cycle();
      chk($sformatf("tbl%0d_valid", i), vld_a, 1'b1);
      chk($sformatf("tbl%0d_imm32", i), imm_a, tbl[i].e32);
      chk($sformatf("tbl%0d_imm64", i), imm_b, tbl[i].e64);
      chk($sformatf("tbl%0d_immz", i), imm_c, tbl[i].ez);
      chk($sformatf("tbl%0d_fmt", i), fmt_a, tbl[i].fmt);
      chk($sformatf("tbl%0d_ill", i), ill_a, tbl[i].ill);
      chk($sformatf("tbl%0d_tag", i), tag_a, 8'(i + 16));
    end
    in_valid = 1'b0;
    repeat (2) cycle();

    // Backpressure: three pushes into a 2-deep buffer while the consumer stalls.
    out_ready = 1'b0;
    delivered.delete();
    in_valid = 1'b1; in_inst = 32'h00100093; in_tag = 8'd1;
    cycle();
    in_inst = 32'h00200093; in_tag = 8'd2;
    cycle();
    chk("bp_in_ready_full", rdy_a, 1'b0);
    chk("bp_head_tag", tag_a, 8'd1);
    in_inst = 32'h00300093; in_tag = 8'd3;
    repeat (2) begin
      cycle();
      chk("bp_hold_tag", tag_a, 8'd1);
      chk("bp_hold_imm", imm_a, 32'd1);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_ready_after_pop", rdy_a, 1'b1);
    cycle();
    in_valid = 1'b0;
    repeat (2) cycle();
    chk("bp_delivered_cnt", delivered.size(), 3);
    for (int k = 0; k < 3 && k < delivered.size(); k++)
      chk("bp_delivered_tag", delivered[k], 8'(k + 1));

    // Flush with a full buffer and a stalled input word.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00400093; in_tag = 8'h10;
    cycle();
    in_tag = 8'h11;
    cycle();
    in_inst = 32'h00500093; in_tag = 8'hAA;
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_valid", vld_a, 1'b0);
    chk("flush_in_ready", rdy_a, 1'b1);
    // Flush while a push would otherwise be accepted.
    in_tag = 8'hBB; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_push_dropped", vld_a, 1'b0);
    out_ready = 1'b1;
    delivered.delete();
    repeat (3) cycle();
    chk("flush_nothing_delivered", delivered.size(), 0);

    // Reset in the middle of a stream holding two entries.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFFC4A303; in_tag = 8'h21;
    cycle();
    in_tag = 8'h22;
    cycle();
    in_valid = 1'b0;
    chk("pre_reset_valid", vld_a, 1'b1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_reset_values("midreset");

    // Randomised traffic against the queue model.
    last_stall = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (!last_stall) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_inst  = rand_inst();
        in_tag   = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
